// File: rtl/store_unit_pkg.sv
// store_unit_pkg: store-type and FSM encodings plus the per-type byte-mask helper.
package store_unit_pkg;
  localparam int REG_LEN = 32;
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BEAT0 = 2'b01, ST_BEAT1 = 2'b10} st_state_e;
  function automatic logic [3:0] base_mask(input logic [1:0] t);
    return t == ST_SB ? 4'b0001 : t == ST_SH ? 4'b0011 : t == ST_SW ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: shifts the store mask and data onto byte lanes across a two-word window.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  st_type,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic        split
);
  assign m8 = {4'b0000, base_mask(st_type)} << off;
  assign d64 = {32'b0, st_data} << {off, 3'b000};
  assign split = |m8[7:4];
endmodule

// File: rtl/store_unit.sv
// store_unit: core store request to byte-enabled req/ack write bus, stalling while busy.
// STORE_MISALIGN_SPLIT_EN splits word-crossing stores into two beats; otherwise they raise st_err.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_W = REG_LEN,
  parameter int DATA_W = REG_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_req,
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack
);
  st_state_e state, state_d;
  logic [7:0] m8;
  logic [63:0] d64;
  logic split, ok, we_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [3:0] be_d;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] hi_wdata, hi_wdata_d;
  logic [3:0] hi_be, hi_be_d;
  assign ok = st_type != 2'b11;
`else
  logic unused_hi;
  assign unused_hi = ^d64[63:32];
  assign ok = st_type != 2'b11 && !split;
`endif
  store_lane_align u_align (
    .st_type (st_type),
    .off     (st_addr[1:0]),
    .st_data (st_data),
    .m8      (m8),
    .d64     (d64),
    .split   (split)
  );
  assign st_busy = state != ST_IDLE;
  always_comb begin
    state_d = state;
    we_d = mem_we;
    addr_d = mem_addr;
    wdata_d = mem_wdata;
    be_d = mem_be;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    hi_wdata_d = hi_wdata;
    hi_be_d = hi_be;
`endif
    case (state)
      ST_IDLE: if (st_req) begin
        err_d = !ok;
        if (ok) begin
          state_d = ST_BEAT0;
          we_d = 1'b1;
          addr_d = {st_addr[ADDR_W-1:2], 2'b00};
          wdata_d = d64[31:0];
          be_d = m8[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
          hi_wdata_d = d64[63:32];
          hi_be_d = m8[7:4];
`endif
        end
      end
      ST_BEAT0: if (mem_ack) begin
`ifdef STORE_MISALIGN_SPLIT_EN
        // a non-empty high mask means the store crosses into the next word
        if (|hi_be) begin
          state_d = ST_BEAT1;
          addr_d = mem_addr + ADDR_W'(4);
          wdata_d = hi_wdata;
          be_d = hi_be;
        end else begin
          state_d = ST_IDLE;
          we_d = 1'b0;
          done_d = 1'b1;
        end
`else
        state_d = ST_IDLE;
        we_d = 1'b0;
        done_d = 1'b1;
`endif
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      ST_BEAT1: if (mem_ack) begin
        state_d = ST_IDLE;
        we_d = 1'b0;
        done_d = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= 4'b0000;
      st_done <= 1'b0;
      st_err <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_wdata <= '0;
      hi_be <= 4'b0000;
`endif
    end else begin
      state <= state_d;
      mem_we <= we_d;
      mem_addr <= addr_d;
      mem_wdata <= wdata_d;
      mem_be <= be_d;
      st_done <= done_d;
      st_err <= err_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_wdata <= hi_wdata_d;
      hi_be <= hi_be_d;
`endif
    end
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: vector table, hand sequences and random stores against a byte-level store model.
module tb_store_unit;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef struct {
    logic [1:0] typ;
    logic [31:0] addr, data;
    int waits;
    logic err, split;
    logic [3:0] be0, be1;
    logic [31:0] a0, w0, a1, w1;
  } vec_t;
  logic clk, rst_n, st_req, mem_ack;
  logic [1:0] st_type;
  logic [31:0] st_addr, st_data;
  logic st_busy, st_done, st_err, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0;
  int failures = 0;
  string ctx = "";
  vec_t tbl[7];
  store_unit dut (
    .clk(clk), .rst_n(rst_n), .st_req(st_req), .st_type(st_type), .st_addr(st_addr),
    .st_data(st_data), .st_busy(st_busy), .st_done(st_done), .st_err(st_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %h expected %h", ctx, name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [1:0] t, input logic [31:0] a, d, input int w,
                              input logic err, split, input logic [3:0] be0, input logic [31:0] a0, w0,
                              input logic [3:0] be1, input logic [31:0] a1, w1);
    vec_t r;
    r.typ = t; r.addr = a; r.data = d; r.waits = w; r.err = err; r.split = split;
    r.be0 = be0; r.a0 = a0; r.w0 = w0; r.be1 = be1; r.a1 = a1; r.w1 = w1;
    return r;
  endfunction
  // byte-by-byte placement of the store into an aligned two-word window
  function automatic vec_t model(input logic [1:0] t, input logic [31:0] a, d, input int w);
    vec_t r;
    logic [7:0] b [8];
    logic [7:0] be8;
    int n, off;
    n = t == 2'd0 ? 1 : t == 2'd1 ? 2 : 4;
    off = int'(a % 4);
    be8 = 8'h00;
    for (int k = 0; k < 8; k++) b[k] = 8'h00;
    for (int j = 0; j < 4; j++) begin
      b[off + j] = d[8*j +: 8];
      if (j < n && t != 2'd3) be8[off + j] = 1'b1;
    end
    r.typ = t; r.addr = a; r.data = d; r.waits = w;
    r.err = t == 2'd3;
    r.split = be8[7:4] != 4'h0;
    r.be0 = be8[3:0]; r.be1 = be8[7:4];
    r.a0 = a - 32'(off); r.a1 = r.a0 + 32'd4;
    r.w0 = {b[3], b[2], b[1], b[0]};
    r.w1 = {b[7], b[6], b[5], b[4]};
    return r;
  endfunction
  task automatic run(input vec_t v);
    logic exp_err;
    exp_err = v.err || (v.split && !SPLIT);
    st_req = 1'b1; st_type = v.typ; st_addr = v.addr; st_data = v.data;
    tick();
    st_req = 1'b0;
    if (exp_err) begin
      chk("err_pulse", st_err, 1);
      chk("err_no_we", mem_we, 0);
      tick();
      chk("err_clear", st_err, 0);
      chk("err_no_done", st_done, 0);
      chk("err_no_we2", mem_we, 0);
      return;
    end
    chk("no_err", st_err, 0);
    for (int b = 0; b < (v.split ? 2 : 1); b++) begin
      for (int w = 0; w <= v.waits; w++) begin
        chk("we", mem_we, 1);
        chk("busy", st_busy, 1);
        chk("done_low", st_done, 0);
        chk("addr", mem_addr, b == 0 ? v.a0 : v.a1);
        chk("be", mem_be, b == 0 ? v.be0 : v.be1);
        chk("wdata", mem_wdata, b == 0 ? v.w0 : v.w1);
        mem_ack = w == v.waits;
        tick();
        mem_ack = 1'b0;
      end
    end
    chk("done", st_done, 1);
    chk("we_off", mem_we, 0);
    chk("idle", st_busy, 0);
    tick();
    chk("done_pulse", st_done, 0);
  endtask
  initial begin
    rst_n = 1'b0; st_req = 1'b0; mem_ack = 1'b0; st_type = 2'b00; st_addr = '0; st_data = '0;
    tbl[0] = mk(2'b10, 32'h100, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 4'h0, 32'h0, 32'h0);
    tbl[1] = mk(2'b00, 32'h203, 32'h000000A5, 3, 0, 0, 4'b1000, 32'h200, 32'hA5000000, 4'h0, 32'h0, 32'h0);
    tbl[2] = mk(2'b01, 32'h1FF, 32'h00001234, 1, 0, 1, 4'b1000, 32'h1FC, 32'h34000000, 4'b0001, 32'h200, 32'h00000012);
    tbl[3] = mk(2'b01, 32'h101, 32'h0000ABCD, 0, 0, 0, 4'b0110, 32'h100, 32'h00ABCD00, 4'h0, 32'h0, 32'h0);
    tbl[4] = mk(2'b11, 32'h000, 32'h12345678, 0, 1, 0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[5] = mk(2'b10, 32'hFFFFFFFE, 32'h11223344, 2, 0, 1, 4'b1100, 32'hFFFFFFFC, 32'h33440000, 4'b0011, 32'h0, 32'h00001122);
    tbl[6] = mk(2'b00, 32'h001, 32'h12345678, 0, 0, 0, 4'b0010, 32'h000, 32'h34567800, 4'h0, 32'h0, 32'h0);
    #2;
    ctx = "reset";
    chk("we", mem_we, 0); chk("addr", mem_addr, 0); chk("wdata", mem_wdata, 0);
    chk("be", mem_be, 0); chk("done", st_done, 0); chk("err", st_err, 0); chk("busy", st_busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      ctx = $sformatf("tbl%0d", i);
      run(tbl[i]);
    end
    ctx = "ack_idle";
    mem_ack = 1'b1;
    tick(); tick();
    chk("we", mem_we, 0); chk("done", st_done, 0); chk("busy", st_busy, 0);
    mem_ack = 1'b0;
    ctx = "b2b";
    st_req = 1'b1; st_type = 2'b00; st_addr = 32'h10; st_data = 32'h0000005A;
    tick();
    st_type = 2'b10; st_addr = 32'h40; st_data = 32'hFFFFFFFF;
    chk("we1", mem_we, 1); chk("be1", mem_be, 4'b0001); chk("addr1", mem_addr, 32'h10);
    tick();
    chk("held_addr", mem_addr, 32'h10); chk("held_be", mem_be, 4'b0001); chk("held_wdata", mem_wdata, 32'h0000005A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("done1", st_done, 1); chk("busy_idle", st_busy, 0);
    st_addr = 32'h20; st_data = 32'hCAFEF00D;
    tick();
    st_req = 1'b0;
    chk("we2", mem_we, 1); chk("addr2", mem_addr, 32'h20); chk("be2", mem_be, 4'b1111); chk("wdata2", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("done2", st_done, 1); chk("we_off", mem_we, 0);
    tick();
    ctx = "rst_mid";
    st_req = 1'b1; st_type = 2'b10; st_addr = 32'h300; st_data = 32'h55AA55AA;
    tick();
    st_req = 1'b0;
    chk("we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("we0", mem_we, 0); chk("addr0", mem_addr, 0); chk("wdata0", mem_wdata, 0); chk("be0", mem_be, 0);
    chk("busy0", st_busy, 0); chk("done0", st_done, 0); chk("err0", st_err, 0);
    tick();
    chk("hold_done", st_done, 0);
    rst_n = 1'b1;
    tick();
    chk("post_we", mem_we, 0); chk("post_done", st_done, 0);
    run(model(2'b10, 32'h304, 32'h0BADF00D, 1));
    for (int i = 0; i < 150; i++) begin
      ctx = $sformatf("rnd%0d", i);
      run(model(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 3))));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
